// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: accepts decoded descriptors, encodes them, buffers and writes them to instruction memory.
// Optional IE_AUTO_HALT_EN appends a HALT word at the end of a program that does not already end in HALT.
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              I_IE_CLK,
    input  logic              I_IE_RESETN,
    input  logic              I_IE_START,
    input  logic              I_IE_VALID,
    output logic              O_IE_READY,
    input  logic [4:0]        I_IE_MNEM,
    input  logic [4:0]        I_IE_RS,
    input  logic [4:0]        I_IE_RT,
    input  logic [4:0]        I_IE_RD,
    input  logic [4:0]        I_IE_SHAMT,
    input  logic [15:0]       I_IE_IMM,
    input  logic [25:0]       I_IE_TARGET,
    input  logic              I_IE_LAST,
    output logic              O_IE_WE,
    output logic [ADDR_W-1:0] O_IE_ADDR,
    output logic [31:0]       O_IE_DATA,
    output logic              O_IE_DONE,
    output logic              O_IE_OVF
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_WORD  = 32'hF800_0000;
    localparam logic [31:0] HALT_WORD = 32'h5400_0000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_exh;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr_out;
    logic [31:0]        r_data;
    logic               r_done;
    logic               r_ovf;

    logic [31:0]        w_word;
    logic [31:0]        w_wr_word;
    logic               w_push;
    logic               w_pop;
    logic               w_halt_append;
    logic               w_clear;
    logic               w_enter_done;
    logic               w_active;

    always_comb begin
        w_word = 32'h0;
        case (I_IE_MNEM)
            5'd0:  w_word = {6'b000000, I_IE_RS, I_IE_RT, I_IE_RD, 5'd0, 6'b100001};
            5'd1:  w_word = {6'b000000, I_IE_RS, I_IE_RT, I_IE_RD, 5'd0, 6'b100011};
            5'd2:  w_word = {6'b000000, I_IE_RS, I_IE_RT, I_IE_RD, 5'd0, 6'b100100};
            5'd3:  w_word = {6'b000000, I_IE_RS, I_IE_RT, I_IE_RD, 5'd0, 6'b100101};
            5'd4:  w_word = {6'b000000, I_IE_RS, I_IE_RT, I_IE_RD, 5'd0, 6'b100110};
            5'd5:  w_word = {6'b000000, I_IE_RS, I_IE_RT, I_IE_RD, 5'd0, 6'b101010};
            5'd6:  w_word = {6'b000000, 5'd0, I_IE_RT, I_IE_RD, I_IE_SHAMT, 6'b000000};
            5'd7:  w_word = {6'b000000, 5'd0, I_IE_RT, I_IE_RD, I_IE_SHAMT, 6'b000010};
            5'd8:  w_word = {6'b000000, 5'd0, I_IE_RT, I_IE_RD, I_IE_SHAMT, 6'b000011};
            5'd9:  w_word = {6'b000000, I_IE_RS, 15'd0, 6'b001000};
            5'd10: w_word = {6'b000000, I_IE_RS, 5'd0, I_IE_RD, 5'd0, 6'b001001};
            5'd11: w_word = {6'b001000, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd12: w_word = {6'b001100, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd13: w_word = {6'b001101, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd14: w_word = {6'b001110, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd15: w_word = {6'b001010, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd16: w_word = {6'b001111, 5'd0, I_IE_RT, I_IE_IMM};
            5'd17: w_word = {6'b000100, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd18: w_word = {6'b000101, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd19: w_word = {6'b100000, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd20: w_word = {6'b100100, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd21: w_word = {6'b100001, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd22: w_word = {6'b100101, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd23: w_word = {6'b100011, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd24: w_word = {6'b100111, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd25: w_word = {6'b101000, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd26: w_word = {6'b101001, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd27: w_word = {6'b101011, I_IE_RS, I_IE_RT, I_IE_IMM};
            5'd28: w_word = {6'b000010, I_IE_TARGET};
            5'd29: w_word = {6'b000011, I_IE_TARGET};
            5'd30: w_word = NOP_WORD;
            default: w_word = HALT_WORD;
        endcase
    end

    // Once the top address has been written (r_exh) nothing more is accepted or popped.
    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign O_IE_READY = (r_state == S_RUN) && (r_count != CNT_W'(FIFO_DEPTH)) && !r_exh;
    assign w_push     = I_IE_VALID && O_IE_READY;
    assign w_pop      = w_active && (r_count != '0) && !r_exh;
    assign w_clear    = ((r_state == S_IDLE) || (r_state == S_DONE)) && I_IE_START;

`ifdef IE_AUTO_HALT_EN
    logic [31:0] r_last_word;
    assign w_halt_append = (r_state == S_DRAIN) && (r_count == '0) && !r_we && !r_exh
                           && (r_last_word != HALT_WORD);
`else
    assign w_halt_append = 1'b0;
`endif

    assign w_wr_word = w_pop ? r_fifo_mem[r_rd_ptr] : HALT_WORD;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (I_IE_START) w_state_next = S_RUN;
            S_RUN: begin
                if (r_exh)                      w_state_next = S_DONE;
                else if (w_push && I_IE_LAST)   w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_exh)                                                 w_state_next = S_DONE;
                else if ((r_count == '0) && !r_we && !w_halt_append)       w_state_next = S_DONE;
            end
            default: if (I_IE_START) w_state_next = S_RUN;
        endcase
    end

    assign w_enter_done = w_active && (w_state_next == S_DONE);

    always_ff @(posedge I_IE_CLK) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge I_IE_CLK) begin
        if (!I_IE_RESETN) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_addr     <= '0;
            r_exh      <= 1'b0;
            r_we       <= 1'b0;
            r_addr_out <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
`ifdef IE_AUTO_HALT_EN
            r_last_word <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_we    <= 1'b0;
            // Entering DONE discards anything still buffered (only non-empty on overflow).
            if (w_enter_done) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            if (w_pop || w_halt_append) begin
                r_we       <= 1'b1;
                r_addr_out <= r_addr;
                r_data     <= w_wr_word;
`ifdef IE_AUTO_HALT_EN
                r_last_word <= w_wr_word;
`endif
                if (r_addr == '1) r_exh  <= 1'b1;
                else              r_addr <= r_addr + 1'b1;
            end
            if (w_enter_done) begin
                r_done <= 1'b1;
                if (r_exh) r_ovf <= 1'b1;
            end
            if (w_clear) begin
                r_addr <= '0;
                r_exh  <= 1'b0;
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end
    end

    assign O_IE_WE   = r_we;
    assign O_IE_ADDR = r_addr_out;
    assign O_IE_DATA = r_data;
    assign O_IE_DONE = r_done;
    assign O_IE_OVF  = r_ovf;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: one 8-bit-address instance and one 2-bit-address instance.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [4:0]  mnem = '0, rs = '0, rt = '0, rd = '0, sh = '0;
    logic [15:0] imm = '0;
    logic [25:0] tgt = '0;
    logic        last = 1'b0;

    logic        rdy_a, we_a, done_a, ovf_a;
    logic [7:0]  addr_a;
    logic [31:0] data_a;
    logic        rdy_b, we_b, done_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;

    int checks = 0;
    int failures = 0;

    logic [7:0]  qa_addr[$];
    logic [31:0] qa_data[$];
    logic [1:0]  qb_addr[$];
    logic [31:0] qb_data[$];

    logic [4:0]  mn_tab[28];
    logic [31:0] exp_tab[28];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut_a (
        .I_IE_CLK(clk), .I_IE_RESETN(rstn), .I_IE_START(start_a), .I_IE_VALID(valid_a),
        .O_IE_READY(rdy_a), .I_IE_MNEM(mnem), .I_IE_RS(rs), .I_IE_RT(rt), .I_IE_RD(rd),
        .I_IE_SHAMT(sh), .I_IE_IMM(imm), .I_IE_TARGET(tgt), .I_IE_LAST(last),
        .O_IE_WE(we_a), .O_IE_ADDR(addr_a), .O_IE_DATA(data_a), .O_IE_DONE(done_a), .O_IE_OVF(ovf_a)
    );

    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) dut_b (
        .I_IE_CLK(clk), .I_IE_RESETN(rstn), .I_IE_START(start_b), .I_IE_VALID(valid_b),
        .O_IE_READY(rdy_b), .I_IE_MNEM(mnem), .I_IE_RS(rs), .I_IE_RT(rt), .I_IE_RD(rd),
        .I_IE_SHAMT(sh), .I_IE_IMM(imm), .I_IE_TARGET(tgt), .I_IE_LAST(last),
        .O_IE_WE(we_b), .O_IE_ADDR(addr_b), .O_IE_DATA(data_b), .O_IE_DONE(done_b), .O_IE_OVF(ovf_b)
    );

    // Record each memory write, sampling the registered strobe just before the edge that ends it.
    always @(posedge clk) begin
        if (we_a) begin
            qa_addr.push_back(addr_a);
            qa_data.push_back(data_a);
            $display("write A addr=%0d data=%08h", addr_a, data_a);
        end
        if (we_b) begin
            qb_addr.push_back(addr_b);
            qb_data.push_back(data_b);
            $display("write B addr=%0d data=%08h", addr_b, data_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Present one descriptor and hold it until accepted or the bound expires; returns at the accepting edge.
    task automatic send(input bit which, input logic [4:0] m, input logic [4:0] r_s, input logic [4:0] r_t,
                        input logic [4:0] r_d, input logic [4:0] s_h, input logic [15:0] im,
                        input logic [25:0] tg, input logic lst, input int limit, output int waited);
        @(negedge clk);
        mnem = m; rs = r_s; rt = r_t; rd = r_d; sh = s_h; imm = im; tgt = tg; last = lst;
        if (which) valid_b = 1'b1; else valid_a = 1'b1;
        waited = 0;
        while (!(which ? rdy_b : rdy_a) && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (waited < limit) @(posedge clk);
    endtask

    task automatic send_a(input logic [4:0] m, input logic [4:0] r_s, input logic [4:0] r_t,
                          input logic [4:0] r_d, input logic [4:0] s_h, input logic [15:0] im,
                          input logic [25:0] tg, input logic lst, output int waited);
        send(1'b0, m, r_s, r_t, r_d, s_h, im, tg, lst, 50, waited);
        chk("accept_a", 32'(waited < 50), 32'd1);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_done(input bit which, input string tag);
        int n;
        n = 0;
        while (!(which ? done_b : done_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int w;
        int stalls;
        int exp_n;

        mn_tab = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16,
                   5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd24, 5'd25, 5'd26, 5'd27, 5'd29, 5'd0, 5'd30, 5'd31};
        exp_tab = '{32'h00221823, 32'h00221824, 32'h00221825, 32'h00221826, 32'h0022182A, 32'h00021902,
                    32'h00021903, 32'h00200008, 32'h00201809, 32'h30221234, 32'h34221234, 32'h38221234,
                    32'h28221234, 32'h3C021234, 32'h10221234, 32'h14221234, 32'h80221234, 32'h90221234,
                    32'h84221234, 32'h94221234, 32'h9C221234, 32'hA0221234, 32'hA4221234, 32'hAC221234,
                    32'h0CABCDEF, 32'h00221821, 32'hF8000000, 32'h54000000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        rstn = 1'b1;

        // Single ADDU with latency check
        pulse_start(1'b0);
        send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, w);
        @(negedge clk);
        valid_a = 1'b0;
        chk("lat_we_early", 32'(we_a), 32'd0);
        @(negedge clk);
        chk("lat_we", 32'(we_a), 32'd1);
        chk("lat_addr", 32'(addr_a), 32'd0);
        chk("lat_data", data_a, 32'h00221821);
        wait_done(1'b0, "addu_done_timeout");
        chk("addu_nwr", 32'(qa_data.size()), 32'd1);
        chk("addu_done", 32'(done_a), 32'd1);
        chk("addu_ovf", 32'(ovf_a), 32'd0);
        chk("addu_we_low", 32'(we_a), 32'd0);

        // Four-instruction stream
        qa_addr.delete(); qa_data.delete();
        pulse_start(1'b0);
        chk("start_clears_done", 32'(done_a), 32'd0);
        send_a(5'd11, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0, w);
        send_a(5'd23, 5'd29, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0, w);
        send_a(5'd6, 5'd0, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, w);
        send_a(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b1, w);
        drop_valid();
        wait_done(1'b0, "stream_done_timeout");
        chk("stream_nwr", 32'(qa_data.size()), 32'd4);
        chk("stream_d0", qa_data[0], 32'h20050010);
        chk("stream_d1", qa_data[1], 32'h8FA40008);
        chk("stream_d2", qa_data[2], 32'h00011100);
        chk("stream_d3", qa_data[3], 32'h08000040);
        chk("stream_a3", 32'(qa_addr[3]), 32'd3);

        // Back-to-back six descriptors
        qa_addr.delete(); qa_data.delete();
        pulse_start(1'b0);
        stalls = 0;
        for (int k = 0; k < 6; k++) begin
            send_a(5'd11, 5'd0, 5'(k), 5'd0, 5'd0, 16'(k), 26'h0, (k == 5), w);
            stalls += w;
        end
        drop_valid();
        wait_done(1'b0, "b2b_done_timeout");
        chk("b2b_no_stall", 32'(stalls), 32'd0);
        chk("b2b_nwr", 32'(qa_data.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b_addr%0d", k), 32'(qa_addr[k]), 32'(k));
            chk($sformatf("b2b_data%0d", k), qa_data[k], 32'h20000000 | (32'(k) << 16) | 32'(k));
        end

        // Every remaining mnemonic with nonzero ignored fields
        qa_addr.delete(); qa_data.delete();
        pulse_start(1'b0);
        for (int k = 0; k < 28; k++)
            send_a(mn_tab[k], 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0ABCDEF, (k == 27), w);
        drop_valid();
        wait_done(1'b0, "tab_done_timeout");
        chk("tab_nwr", 32'(qa_data.size()), 32'd28);
        for (int k = 0; k < 28; k++)
            chk($sformatf("tab_mnem%0d", mn_tab[k]), qa_data[k], exp_tab[k]);

        // Two NOPs: HALT appended only with the auto-halt build
        qa_addr.delete(); qa_data.delete();
        pulse_start(1'b0);
        send_a(5'd30, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h0, 1'b0, w);
        send_a(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, w);
        drop_valid();
        wait_done(1'b0, "nop_done_timeout");
`ifdef IE_AUTO_HALT_EN
        exp_n = 3;
        chk("nop_halt_data", qa_data[2], 32'h54000000);
        chk("nop_halt_addr", 32'(qa_addr[2]), 32'd2);
`else
        exp_n = 2;
`endif
        chk("nop_nwr", 32'(qa_data.size()), 32'(exp_n));
        chk("nop_d0", qa_data[0], 32'hF8000000);
        chk("nop_d1", qa_data[1], 32'hF8000000);
        chk("nop_a1", 32'(qa_addr[1]), 32'd1);

        // Address-space overflow on the 2-bit instance
        pulse_start(1'b1);
        for (int k = 0; k < 6; k++)
            send(1'b1, 5'd11, 5'd0, 5'(k), 5'd0, 5'd0, 16'(k), 26'h0, (k == 5), 10, w);
        drop_valid();
        wait_done(1'b1, "ovf_done_timeout");
        chk("ovf_nwr", 32'(qb_data.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_addr%0d", k), 32'(qb_addr[k]), 32'(k));
            chk($sformatf("ovf_data%0d", k), qb_data[k], 32'h20000000 | (32'(k) << 16) | 32'(k));
        end
        chk("ovf_flag", 32'(ovf_b), 32'd1);
        chk("ovf_done", 32'(done_b), 32'd1);
        chk("ovf_we_low", 32'(we_b), 32'd0);

        // Reset in the middle of a load
        pulse_start(1'b0);
        for (int k = 0; k < 3; k++)
            send_a(5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'(k), 26'h0, 1'b0, w);
        @(negedge clk);
        valid_a = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        qa_addr.delete(); qa_data.delete();
        chk("mid_rst_we", 32'(we_a), 32'd0);
        chk("mid_rst_addr", 32'(addr_a), 32'd0);
        chk("mid_rst_data", data_a, 32'd0);
        chk("mid_rst_ready", 32'(rdy_a), 32'd0);
        chk("mid_rst_done", 32'(done_a), 32'd0);
        chk("mid_rst_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_nwr", 32'(qa_data.size()), 32'd0);
        chk("post_rst_ready", 32'(rdy_a), 32'd0);
        chk("post_rst_done", 32'(done_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
